tile_scroll_gen: RTL

Parametrised scrolling tile-pattern generator for the VGA pattern pipeline. Produces a registered 6-bit RGB pixel from the current beam coordinate. Supports four tile modes, four scroll directions, programmable foreground/background colours and a fixed-point per-frame scroll step. Sits beside the other pattern generators and is selected by the pattern mux through `pattern_enable`.

---
 rtl/tile_scroll_gen_if.sv | 32 +++
 rtl/tile_scroll_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/tile_scroll_gen_if.sv
// Pixel-side bundle for the scrolling tile generator: beam coordinate,
// frame strobe, scroll/tile configuration and the registered colour output.
interface tile_scroll_gen_if #(
    parameter int X_W    = 10,
    parameter int Y_W    = 10,
    parameter int STEP_W = 3
);
    logic              pattern_enable;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              next_frame;
    logic [STEP_W-1:0] step_size;
    logic [1:0]        dir;
    logic [1:0]        mode;
    logic [5:0]        fg_color;
    logic [5:0]        bg_color;
    logic [5:0]        rgb;

    // The timing/control side drives coordinates and configuration
    modport master (
        output pattern_enable, x, y, next_frame, step_size, dir, mode,
               fg_color, bg_color,
        input  rgb
    );

    // The generator consumes them and returns the pixel colour
    modport slave (
        input  pattern_enable, x, y, next_frame, step_size, dir, mode,
               fg_color, bg_color,
        output rgb
    );
endinterface

// File: rtl/tile_scroll_gen.sv
// Scrolling tile-pattern generator. Keeps fixed-point scroll accumulators
// that advance once per frame. It maps the beam coordinate through the
// integer offsets onto a tile grid and emits a registered 6-bit colour.
// Configuration is shadowed at the frame boundary, so mid-frame edits stay
// invisible until the next frame starts.
module tile_scroll_gen #(
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int TILE_LOG2 = 5,
    parameter int STEP_W    = 3,
    parameter int FRAC_BITS = 2,
    parameter int OFFSET_W  = 10
) (
    input logic             clk,
    input logic             rst,
    tile_scroll_gen_if.slave bus
);

    localparam int ACC_W = OFFSET_W + FRAC_BITS;
    localparam int C_W   = (X_W > Y_W) ? X_W : Y_W;

    localparam logic [5:0] FG_RESET = 6'b100100;
    localparam logic [5:0] BG_RESET = 6'b000000;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        MODE_CHECKER = 2'b00,
        MODE_VSTRIPE = 2'b01,
        MODE_HSTRIPE = 2'b10,
        MODE_DIAG    = 2'b11
    } mode_t;

    logic [ACC_W-1:0]    acc_x;
    logic [ACC_W-1:0]    acc_y;
    mode_t               mode_q;
    dir_t                dir_q;
    logic [5:0]          fg_q;
    logic [5:0]          bg_q;

    logic [OFFSET_W-1:0] ox;
    logic [OFFSET_W-1:0] oy;
    logic [ACC_W-1:0]    step_ext;
    logic [X_W-1:0]      sx;
    logic [Y_W-1:0]      sy;
    logic [C_W-1:0]      diag_sum;
    logic                tx;
    logic                ty;
    logic                tile_bit;
    logic [5:0]          pixel_next;
    logic                scroll_now;

    // Integer part of each accumulator is the pixel offset; step is unsigned
    assign ox         = acc_x[ACC_W-1:FRAC_BITS];
    assign oy         = acc_y[ACC_W-1:FRAC_BITS];
    assign step_ext   = ACC_W'(bus.step_size);
    assign scroll_now = bus.next_frame && bus.pattern_enable;

    // Accumulators advance along the shadowed direction; the load of dir_q in
    // the same cycle only takes effect for the following frame
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_x <= '0;
            acc_y <= '0;
        end else if (scroll_now) begin
            case (dir_q)
                DIR_RIGHT: acc_x <= acc_x + step_ext;
                DIR_LEFT:  acc_x <= acc_x - step_ext;
                DIR_DOWN:  acc_y <= acc_y + step_ext;
                DIR_UP:    acc_y <= acc_y - step_ext;
                default:   ;
            endcase
        end
    end

    // Configuration shadows reload at every frame boundary, even when disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_CHECKER;
            dir_q  <= DIR_RIGHT;
            fg_q   <= FG_RESET;
            bg_q   <= BG_RESET;
        end else if (bus.next_frame) begin
            mode_q <= mode_t'(bus.mode);
            dir_q  <= dir_t'(bus.dir);
            fg_q   <= bus.fg_color;
            bg_q   <= bus.bg_color;
        end
    end

    // Scrolled coordinate, tile selection and colour choice for this pixel
    always_comb begin
        sx       = bus.x + X_W'(ox);
        sy       = bus.y + Y_W'(oy);
        diag_sum = C_W'(sx) + C_W'(sy);
        tx       = sx[TILE_LOG2];
        ty       = sy[TILE_LOG2];
        tile_bit = 1'b0;
        case (mode_q)
            MODE_CHECKER: tile_bit = tx ^ ty;
            MODE_VSTRIPE: tile_bit = tx;
            MODE_HSTRIPE: tile_bit = ty;
            MODE_DIAG:    tile_bit = diag_sum[TILE_LOG2];
            default:      tile_bit = 1'b0;
        endcase
        pixel_next = 6'b000000;
        if (bus.pattern_enable) begin
            pixel_next = tile_bit ? fg_q : bg_q;
        end
    end

    // Output colour register, one cycle behind the sampled coordinate
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rgb <= 6'b000000;
        end else begin
            bus.rgb <= pixel_next;
        end
    end

endmodule
